banner_overlay: RTL

//  Parametrised successor to the single-bitmap game-over overlay. Stores NUM_MSG 1-bit banners of
//  IMG_W x IMG_H in one ROM and places the selected banner at (X0,Y0) in the VGA raster.

---
 rtl/pong_pkg.sv | 22 ++
 rtl/banner_rom.sv | 22 ++
 rtl/banner_overlay.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared pong display constants, the banner overlay state encoding and the
// pattern used to fill the banner ROM.
package pong_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int COORD_W  = 13;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REVEAL = 2'd1,
      SHOW   = 2'd2
   } state_t;

   // ROM image bit for a flat address. Bit = ~(a[0] ^ a[1]) inside banner 0,
   // inverted for every banner past the first. The banners therefore differ
   // from each other and are not uniform inside one banner.
   function automatic logic banner_bit(input logic [31:0] addr, input int msg_words);
      return ~(addr[0] ^ addr[1] ^ (addr >= 32'(msg_words)));
   endfunction

endpackage

// File: rtl/banner_rom.sv
// Single-port banner image ROM with a registered read (one cycle of latency).
// The contents are generated from a fixed pattern, so the image needs no
// external file.
module banner_rom
   import pong_pkg::*;
#(
   parameter int DEPTH     = 35136,
   parameter int ADDR_W    = 16,
   parameter int MSG_WORDS = 17568
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   output logic              data
);

   // registered read; addresses past the image return dark
   always_ff @(posedge clk) begin
      if (32'(addr) < 32'(DEPTH)) data <= banner_bit(32'(addr), MSG_WORDS);
      else                        data <= 1'b0;
   end

endmodule

// File: rtl/banner_overlay.sv
// Banner overlay: places one of NUM_MSG 1-bit banners at (X0,Y0) in the raster,
// with a frame-locked left-to-right reveal wipe and optional blinking.
// pixel/in_box follow row/col by two clocks: stage 1 registers the box test and
// the ROM address, and stage 2 is the ROM read.
module banner_overlay
   import pong_pkg::*;
#(
   parameter int NUM_MSG      = 2,
   parameter int IMG_W        = 244,
   parameter int IMG_H        = 72,
   parameter int X0           = 181,
   parameter int Y0           = 209,
   parameter int COORD_W      = pong_pkg::COORD_W,
   parameter int REVEAL_STEP  = 8,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic [COORD_W-1:0]                            row,
   input  logic [COORD_W-1:0]                            col,
   input  logic                                          frame_start,
   input  logic                                          show,
   input  logic [((NUM_MSG > 1) ? $clog2(NUM_MSG) : 1)-1:0] show_sel,
   input  logic                                          blink_en,
   output logic                                          pixel,
   output logic                                          in_box,
   output logic                                          busy,
   output logic [1:0]                                    state_dbg,
   output logic [$clog2(IMG_W+1)-1:0]                    reveal_dbg
);

   localparam int SEL_W     = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
   localparam int MSG_WORDS = IMG_W * IMG_H;
   localparam int DEPTH     = NUM_MSG * MSG_WORDS;
   localparam int ADDR_W    = $clog2(DEPTH);
   localparam int RC_W      = $clog2(IMG_W + 1);
   localparam int BC_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [COORD_W-1:0] X_LO = COORD_W'(X0);
   localparam logic [COORD_W-1:0] X_HI = COORD_W'(X0 + IMG_W);
   localparam logic [COORD_W-1:0] Y_LO = COORD_W'(Y0);
   localparam logic [COORD_W-1:0] Y_HI = COORD_W'(Y0 + IMG_H);

   state_t            state;
   logic [SEL_W-1:0]  sel_q;
   logic [RC_W-1:0]   reveal_cols;
   logic [BC_W-1:0]   blink_cnt;
   logic              blink_phase;
   logic              sel_ok;
   logic              show_ok;
   logic [RC_W:0]     step_sum;

   logic [COORD_W-1:0] dx, dy;
   logic               box;
   logic               reveal_ok;
   logic [ADDR_W-1:0]  addr;

   logic [ADDR_W-1:0]  addr_q;
   logic               box_q, ok_q, gate_q;
   logic               box2_q, gate2_q;
   logic               rom_data;

   // Only a select that does not name a stored banner can be out of range.
   // When every code of show_sel is a valid banner, the range check is not built.
   if ((1 << SEL_W) > NUM_MSG) begin : g_sel_chk
      assign sel_ok = (show_sel < SEL_W'(NUM_MSG));
   end else begin : g_sel_all
      assign sel_ok = 1'b1;
   end

   // An out-of-range select behaves exactly like show=0.
   assign show_ok  = show & sel_ok;
   assign step_sum = {1'b0, reveal_cols} + (RC_W+1)'(REVEAL_STEP);

   // Control FSM: entry latches the banner, REVEAL widens the wipe per frame,
   // SHOW runs the blink. Dropping show returns to IDLE from any state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         sel_q       <= '0;
         reveal_cols <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (!show_ok) begin
         state       <= IDLE;
         reveal_cols <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (state != IDLE && show_sel != sel_q) begin
         // switching banners restarts the wipe from column 0
         state       <= REVEAL;
         sel_q       <= show_sel;
         reveal_cols <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               // a frame_start in this same cycle is not a wipe step
               state       <= REVEAL;
               sel_q       <= show_sel;
               reveal_cols <= '0;
            end
            REVEAL: begin
               if (frame_start) begin
                  if (step_sum >= (RC_W+1)'(IMG_W)) begin
                     reveal_cols <= RC_W'(IMG_W);
                     state       <= SHOW;
                  end else begin
                     reveal_cols <= step_sum[RC_W-1:0];
                  end
               end
            end
            SHOW: begin
               if (blink_en) begin
                  if (frame_start) begin
                     if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                        blink_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                     end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                     end
                  end
               end else begin
                  blink_cnt   <= '0;
                  blink_phase <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stage-1 math. The address is built at full ROM width before the adds.
   // Outside the box the address is forced to 0, so the ROM is never indexed
   // out of range.
   always_comb begin
      dx        = col - X_LO;
      dy        = row - Y_LO;
      box       = (col >= X_LO) && (col < X_HI) && (row >= Y_LO) && (row < Y_HI);
      reveal_ok = (dx < COORD_W'(reveal_cols));
      addr      = '0;
      if (box) begin
         addr = ADDR_W'(sel_q) * ADDR_W'(MSG_WORDS)
              + ADDR_W'(dy) * ADDR_W'(IMG_W)
              + ADDR_W'(dx);
      end
   end

   // Stage-1 registers. The display gate captures the state seen in this cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= '0;
         box_q  <= 1'b0;
         ok_q   <= 1'b0;
         gate_q <= 1'b0;
      end else begin
         addr_q <= addr;
         box_q  <= box;
         ok_q   <= reveal_ok;
         gate_q <= (state != IDLE) && blink_phase;
      end
   end

   banner_rom #(
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W),
      .MSG_WORDS (MSG_WORDS)
   ) u_rom (
      .clk  (clk),
      .addr (addr_q),
      .data (rom_data)
   );

   // Stage-2 registers, aligned with the ROM read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         box2_q  <= 1'b0;
         gate2_q <= 1'b0;
      end else begin
         box2_q  <= box_q;
         gate2_q <= box_q & ok_q & gate_q;
      end
   end

   assign pixel      = rom_data & gate2_q;
   assign in_box     = box2_q;
   assign busy       = (state != IDLE);
   assign state_dbg  = state;
   assign reveal_dbg = reveal_cols;

endmodule
